cachefill: RTL and testbench

Line-replacement controller that consumes the one-hot victim way chosen by the cache replacement policy. On a miss it latches the victim, writes back the old line if it is dirty, and fetches the new line beat by beat. It then commits the fill by asserting SetValid/LRUWriteEn back to the tag array and the replacement policy. It sits between the cache tag/data arrays and the bus interface; the data path is external, and this block only sequences addresses, beat indices and write strobes.

---
 rtl/cachefill.sv | 133 +++++++++++++
 tb/tb_cachefill.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cachefill.sv
// Line-replacement sequencer: captures a miss and its victim, writes the old line back
// when dirty, fetches the new line beat by beat, then commits the fill for one cycle.
module cachefill #(
  parameter  int NUMWAYS   = 4,
  parameter  int SETLEN    = 7,
  parameter  int TAGLEN    = 20,
  parameter  int LINELEN   = 256,
  parameter  int AHBW      = 64,
  localparam int BEATS     = LINELEN / AHBW,
  localparam int BEATLEN   = $clog2(BEATS),
  localparam int OFFSETLEN = $clog2(LINELEN / 8),
  localparam int PABITS    = TAGLEN + SETLEN + OFFSETLEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Miss,
  input  logic [TAGLEN-1:0]  MissTag,
  input  logic [SETLEN-1:0]  MissSet,
  input  logic [NUMWAYS-1:0] VictimWay,
  input  logic               VictimDirty,
  input  logic [TAGLEN-1:0]  VictimTag,
  input  logic               BusAck,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [PABITS-1:0]  BusAdr,
  output logic [BEATLEN-1:0] BeatIdx,
  output logic               FetchBeatWrEn,
  output logic [NUMWAYS-1:0] FillWay,
  output logic               SetValid,
  output logic               ClearDirty,
  output logic               LRUWriteEn,
  output logic               Busy,
  output logic               Done
);

  // state     | meaning
  // IDLE      | waiting for Miss; victim and miss address captured on Miss
  // WRITEBACK | streaming the dirty victim line out, one beat per BusAck
  // FETCH     | streaming the new line in, each acked beat written to FillWay
  // COMMIT    | single cycle: set valid, clear dirty, advance replacement state
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, COMMIT} state_t;

  localparam logic [BEATLEN-1:0] LAST_BEAT = BEATLEN'(BEATS - 1);

  state_t              state;
  logic [BEATLEN-1:0]  beat_idx;
  logic [NUMWAYS-1:0]  fill_way;
  logic [TAGLEN-1:0]   victim_tag_q;
  logic [TAGLEN-1:0]   miss_tag_q;
  logic [SETLEN-1:0]   miss_set_q;
  logic                bus_req_q;
  logic                bus_write_q;
  logic                busy_q;
  logic                commit_q;
  logic [TAGLEN-1:0]   adr_tag;

  // Control outputs are registered alongside the state so they change only on edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat_idx     <= '0;
      fill_way     <= '0;
      victim_tag_q <= '0;
      miss_tag_q   <= '0;
      miss_set_q   <= '0;
      bus_req_q    <= 1'b0;
      bus_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Miss) begin
            fill_way     <= VictimWay;
            victim_tag_q <= VictimTag;
            miss_tag_q   <= MissTag;
            miss_set_q   <= MissSet;
            beat_idx     <= '0;
            busy_q       <= 1'b1;
            bus_req_q    <= 1'b1;
            bus_write_q  <= VictimDirty;
            state        <= VictimDirty ? WRITEBACK : FETCH;
          end
        end
        WRITEBACK: begin
          if (BusAck) begin
            if (beat_idx == LAST_BEAT) begin
              beat_idx    <= '0;
              bus_write_q <= 1'b0;
              state       <= FETCH;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        FETCH: begin
          if (BusAck) begin
            if (beat_idx == LAST_BEAT) begin
              beat_idx  <= '0;
              bus_req_q <= 1'b0;
              commit_q  <= 1'b1;
              state     <= COMMIT;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        COMMIT: begin
          commit_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the writeback phase addresses the old line; everything else uses the miss tag.
  assign adr_tag = (state == WRITEBACK) ? victim_tag_q : miss_tag_q;

  assign BusAdr        = {adr_tag, miss_set_q, beat_idx, {(OFFSETLEN - BEATLEN){1'b0}}};
  assign BusReq        = bus_req_q;
  assign BusWrite      = bus_write_q;
  assign BeatIdx       = beat_idx;
  assign FetchBeatWrEn = (state == FETCH) && BusAck;
  assign FillWay       = fill_way;
  assign SetValid      = commit_q;
  assign ClearDirty    = commit_q;
  assign LRUWriteEn    = commit_q;
  assign Busy          = busy_q;
  assign Done          = commit_q;

endmodule

// File: tb/tb_cachefill.sv
// Bench for cachefill: directed scenarios plus random traffic, all checked against
// a transaction-queue model of the expected bus beats and commit cycle.
`timescale 1ns/1ps
module tb_cachefill;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        miss = 1'b0;
  logic [19:0] miss_tag = '0;
  logic [6:0]  miss_set = '0;
  logic [3:0]  victim_way = '0;
  logic        victim_dirty = 1'b0;
  logic [19:0] victim_tag = '0;
  logic        bus_ack = 1'b0;

  logic        bus_req, bus_write, fetch_we, set_valid, clear_dirty, lru_we, busy, done;
  logic [31:0] bus_adr;
  logic [1:0]  beat_idx;
  logic [3:0]  fill_way;

  cachefill dut (
    .clk(clk), .reset(reset), .Miss(miss), .MissTag(miss_tag), .MissSet(miss_set),
    .VictimWay(victim_way), .VictimDirty(victim_dirty), .VictimTag(victim_tag),
    .BusAck(bus_ack), .BusReq(bus_req), .BusWrite(bus_write), .BusAdr(bus_adr),
    .BeatIdx(beat_idx), .FetchBeatWrEn(fetch_we), .FillWay(fill_way),
    .SetValid(set_valid), .ClearDirty(clear_dirty), .LRUWriteEn(lru_we),
    .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  beat;
    logic [31:0] adr;
  } beat_t;

  beat_t       q[$];
  logic        m_commit = 1'b0;
  logic [3:0]  m_fill = '0;

  int n_checks = 0;
  int n_errors = 0;
  int done_count = 0;

  logic        s_done, s_busy, s_fwe;
  logic [31:0] s_adr;
  logic [1:0]  s_beat;
  logic [31:0] seen_adr[$];
  logic        seen_wr[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_adr(input logic [19:0] tag, input logic [6:0] set, input int b);
    return 32'(tag) * 32'd4096 + 32'(set) * 32'd32 + 32'(b) * 32'd8;
  endfunction

  function automatic beat_t mk_beat(input logic wr, input logic [19:0] tag, input logic [6:0] set,
                                    input int b);
    beat_t r;
    r.wr   = wr;
    r.beat = 2'(b);
    r.adr  = mk_adr(tag, set, b);
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    m_commit = 1'b0;
    m_fill   = '0;
  endtask

  // Advance the model at a clock edge using the inputs the DUT sampled there.
  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else if (q.size() > 0) begin
      if (bus_ack) begin
        void'(q.pop_front());
        if (q.size() == 0) m_commit = 1'b1;
      end
    end else if (m_commit) begin
      m_commit = 1'b0;
    end else if (miss) begin
      m_fill = victim_way;
      if (victim_dirty)
        for (int b = 0; b < 4; b++) q.push_back(mk_beat(1'b1, victim_tag, miss_set, b));
      for (int b = 0; b < 4; b++) q.push_back(mk_beat(1'b0, miss_tag, miss_set, b));
    end
  endtask

  task automatic compare_outputs();
    logic e_busy, e_req, e_wr, e_fwe, e_commit;
    if (q.size() > 0) begin
      e_busy = 1'b1; e_req = 1'b1; e_wr = q[0].wr;
      e_fwe = !q[0].wr && bus_ack; e_commit = 1'b0;
      check("bus_adr", bus_adr, q[0].adr);
      check("beat_idx", beat_idx, q[0].beat);
    end else begin
      e_busy = m_commit; e_req = 1'b0; e_wr = 1'b0; e_fwe = 1'b0; e_commit = m_commit;
    end
    check("busy", busy, e_busy);
    check("bus_req", bus_req, e_req);
    check("bus_write", bus_write, e_wr);
    check("fetch_we", fetch_we, e_fwe);
    check("set_valid", set_valid, e_commit);
    check("clear_dirty", clear_dirty, e_commit);
    check("lru_we", lru_we, e_commit);
    check("done", done, e_commit);
    check("fill_way", fill_way, m_fill);
    s_done = done; s_busy = busy; s_fwe = fetch_we; s_adr = bus_adr; s_beat = beat_idx;
    if (bus_req && bus_ack) begin
      seen_adr.push_back(bus_adr);
      seen_wr.push_back(bus_write);
    end
    if (done) done_count++;
  endtask

  // Called at posedge+1 with inputs already driven; checks mid-cycle, then steps an edge.
  task automatic cycle();
    #4;
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_done(input int stall_from, input int stall_len, input int poke_at,
                           output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      bus_ack = !(i >= stall_from && i < stall_from + stall_len);
      if (i == poke_at) begin
        miss = 1'b1;
        victim_way = 4'b0001;
      end else begin
        miss = 1'b0;
      end
      cycle();
      if (i >= stall_from && i < stall_from + stall_len) begin
        check("stall_adr", s_adr, 32'h123450B0);
        check("stall_beat", s_beat, 2);
        check("stall_fwe", s_fwe, 0);
      end
      if (s_done) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("done_timeout", s_done, 1);
  endtask

  task automatic start_miss(input logic dirty, input logic [19:0] mtag, input logic [6:0] set,
                            input logic [19:0] vtag, input logic [3:0] way);
    miss = 1'b1; victim_dirty = dirty; miss_tag = mtag; miss_set = set;
    victim_tag = vtag; victim_way = way; bus_ack = 1'b1;
    seen_adr.delete(); seen_wr.delete();
    cycle();
    miss = 1'b0;
  endtask

  initial begin
    int n;
    int d0;
    logic b_busy[14];
    logic b_done[14];

    #3;
    check("rst_busy", busy, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_adr", bus_adr, 0);
    check("rst_beat_idx", beat_idx, 0);
    check("rst_fill_way", fill_way, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    cycle();

    // clean miss
    start_miss(1'b0, 20'h12345, 7'h05, 20'h0FFFF, 4'b0100);
    wait_done(0, 0, 0, n);
    check("clean_latency", n, 5);
    check("clean_beats", seen_adr.size(), 4);
    for (int k = 0; k < 4 && k < seen_adr.size(); k++) begin
      check("clean_adr", seen_adr[k], 32'h123450A0 + 32'(k * 8));
      check("clean_wr", seen_wr[k], 0);
    end
    check("clean_fill", fill_way, 4'b0100);

    // dirty miss
    start_miss(1'b1, 20'h12345, 7'h05, 20'h00ABC, 4'b0010);
    wait_done(0, 0, 0, n);
    check("dirty_latency", n, 9);
    check("dirty_beats", seen_adr.size(), 8);
    for (int k = 0; k < 4 && k + 4 < seen_adr.size(); k++) begin
      check("wb_adr", seen_adr[k], 32'h00ABC0A0 + 32'(k * 8));
      check("wb_wr", seen_wr[k], 1);
      check("fetch_adr", seen_adr[k + 4], 32'h123450A0 + 32'(k * 8));
      check("fetch_wr", seen_wr[k + 4], 0);
    end

    // ack stall at fetch beat 2 (cycles 3..5 after capture)
    start_miss(1'b0, 20'h12345, 7'h05, 20'h0, 4'b1000);
    wait_done(3, 3, 0, n);
    check("stall_latency", n, 8);

    // miss pulse while busy is ignored
    cycle();
    d0 = done_count;
    start_miss(1'b0, 20'h12345, 7'h05, 20'h0, 4'b0100);
    wait_done(0, 0, 2, n);
    check("ignore_latency", n, 5);
    miss = 1'b0;
    repeat (6) cycle();
    check("ignore_dones", done_count - d0, 1);
    check("ignore_fill", fill_way, 4'b0100);

    // reset during fetch beat 2
    start_miss(1'b0, 20'h12345, 7'h05, 20'h0, 4'b0100);
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_adr", bus_adr, 0);
    check("mid_rst_beat", beat_idx, 0);
    check("mid_rst_fwe", fetch_we, 0);
    check("mid_rst_valid", set_valid, 0);
    check("mid_rst_fill", fill_way, 0);
    model_clear();
    cycle();
    reset = 1'b0;
    start_miss(1'b0, 20'h0F0F0, 7'h11, 20'h0, 4'b0010);
    cycle();
    check("post_rst_adr", s_adr, 32'h0F0F0220);
    check("post_rst_beat", s_beat, 0);
    wait_done(0, 0, 0, n);
    check("post_rst_latency", n, 4);

    // back-to-back with Miss held high
    cycle();
    miss = 1'b1; victim_dirty = 1'b0; miss_tag = 20'h12345; miss_set = 7'h05;
    victim_way = 4'b0100; bus_ack = 1'b1;
    d0 = done_count;
    for (int i = 0; i < 14; i++) begin
      cycle();
      b_busy[i] = s_busy;
      b_done[i] = s_done;
    end
    check("b2b_dones", done_count - d0, 2);
    n = -1;
    for (int i = 0; i < 12; i++) if (b_done[i] && n < 0) n = i;
    check("b2b_first_done", n, 5);
    if (n >= 0 && n < 12) begin
      check("b2b_gap", b_busy[n + 1], 0);
      check("b2b_restart", b_busy[n + 2], 1);
    end
    miss = 1'b0;
    wait_done(0, 0, 0, n);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        model_clear();
      end else begin
        reset = 1'b0;
      end
      miss         = ($urandom_range(0, 3) == 0);
      victim_way   = 4'b0001 << $urandom_range(0, 3);
      victim_dirty = 1'($urandom_range(0, 1));
      victim_tag   = 20'($urandom);
      miss_tag     = 20'($urandom);
      miss_set     = 7'($urandom);
      bus_ack      = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
